// File: rtl/conv_cycle_model.sv
// Queued analytic cycle-cost model for the convolution engines (dense, deformable, depthwise,
// pointwise). Defining CONV_CYCLE_STATS_EN adds the busy_total_o busy-cycle counter output.
module conv_cycle_model #(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned ACC_WIDTH      = 48,
    parameter int unsigned PE_COUNT       = 64,
    parameter int unsigned INTERP_COST    = 2,
    parameter int unsigned SPARSITY_SHIFT = 2,
    parameter int unsigned QDEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [1:0]               req_mode_i,
    input  logic [WIDTH-1:0]         req_rows_i,
    input  logic [WIDTH-1:0]         req_cols_i,
    input  logic [WIDTH-1:0]         req_in_ch_i,
    input  logic [WIDTH-1:0]         req_out_ch_i,
    input  logic [1:0]               req_stride_i,
    input  logic                     abort_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [ACC_WIDTH-1:0]     done_cycles_o,
    output logic [1:0]               done_mode_o,
    output logic [15:0]              job_count_o,
    output logic [$clog2(QDEPTH):0]  q_level_o
`ifdef CONV_CYCLE_STATS_EN
    ,
    output logic [ACC_WIDTH-1:0]     busy_total_o
`endif
);

    localparam int unsigned AW = $clog2(QDEPTH);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StCalc1 = 3'd1;
    localparam logic [2:0] StCalc2 = 3'd2;
    localparam logic [2:0] StCalc3 = 3'd3;
    localparam logic [2:0] StRun   = 3'd4;

    localparam logic [1:0] ModeDense  = 2'd0;
    localparam logic [1:0] ModeDeform = 2'd1;
    localparam logic [1:0] ModeDepth  = 2'd2;
    localparam logic [1:0] ModePoint  = 2'd3;

    typedef struct packed {
        logic [1:0]       mode;
        logic [WIDTH-1:0] rows;
        logic [WIDTH-1:0] cols;
        logic [WIDTH-1:0] in_ch;
        logic [WIDTH-1:0] out_ch;
        logic [1:0]       stride;
    } desc_t;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    desc_t         fifo_mem [QDEPTH];
    desc_t         req_desc;
    desc_t         head_desc;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   q_cnt_q;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;

    always_comb begin
        req_desc        = '0;
        req_desc.mode   = req_mode_i;
        req_desc.rows   = req_rows_i;
        req_desc.cols   = req_cols_i;
        req_desc.in_ch  = req_in_ch_i;
        req_desc.out_ch = req_out_ch_i;
        req_desc.stride = req_stride_i;
    end

    assign fifo_empty  = (q_cnt_q == '0);
    assign fifo_full   = (q_cnt_q == (AW+1)'(QDEPTH));
    assign req_ready_o = !fifo_full && !abort_i && !rst;
    assign push        = req_valid_i && req_ready_o;
    assign head_desc   = fifo_mem[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            q_cnt_q  <= '0;
        end else if (abort_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            q_cnt_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            q_cnt_q <= q_cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= req_desc;
    end

    // ------------------------------------------------------------------
    // Cost pipeline and run counter
    // ------------------------------------------------------------------
    logic [2:0]           state_q, state_d;
    desc_t                cur_q, cur_d;
    logic [ACC_WIDTH-1:0] pix_q, pix_d;
    logic [ACC_WIDTH-1:0] macs_q, macs_d;
    logic [ACC_WIDTH-1:0] interp_q, interp_d;
    logic [ACC_WIDTH-1:0] cost_q, cost_d;
    logic [ACC_WIDTH-1:0] count_q, count_d;
    logic                 done_q, done_d;
    logic [ACC_WIDTH-1:0] done_cycles_q, done_cycles_d;
    logic [1:0]           done_mode_q, done_mode_d;
    logic [15:0]          job_count_q, job_count_d;

    logic                 stride2;
    logic [ACC_WIDTH-1:0] rows_ext, cols_ext, in_ext, out_ext;
    logic [ACC_WIDTH-1:0] rows_ceil, cols_ceil;
    logic [ACC_WIDTH-1:0] full_macs;
    logic [ACC_WIDTH-1:0] t_calc;
    logic                 complete;

    assign stride2   = (cur_q.stride == 2'd2);
    assign rows_ext  = ACC_WIDTH'(cur_q.rows);
    assign cols_ext  = ACC_WIDTH'(cur_q.cols);
    assign in_ext    = ACC_WIDTH'(cur_q.in_ch);
    assign out_ext   = ACC_WIDTH'(cur_q.out_ch);
    assign rows_ceil = stride2 ? ((rows_ext + ACC_WIDTH'(1)) >> 1) : rows_ext;
    assign cols_ceil = stride2 ? ((cols_ext + ACC_WIDTH'(1)) >> 1) : cols_ext;
    assign full_macs = pix_q * out_ext * in_ext * ACC_WIDTH'(9);
    assign t_calc    = interp_q +
                       (macs_q + ACC_WIDTH'(PE_COUNT - 1)) / ACC_WIDTH'(PE_COUNT);

    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        pix_d         = pix_q;
        macs_d        = macs_q;
        interp_d      = interp_q;
        cost_d        = cost_q;
        count_d       = count_q;
        done_d        = 1'b0;
        done_cycles_d = done_cycles_q;
        done_mode_d   = done_mode_q;
        job_count_d   = job_count_q;
        pop           = 1'b0;
        complete      = 1'b0;

        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    cur_d   = head_desc;
                    state_d = StCalc1;
                end
            end
            StCalc1: begin
                pix_d   = rows_ceil * cols_ceil;
                state_d = StCalc2;
            end
            StCalc2: begin
                interp_d = '0;
                case (cur_q.mode)
                    ModeDense:  macs_d = full_macs;
                    ModeDeform: begin
                        macs_d   = full_macs >> SPARSITY_SHIFT;
                        interp_d = pix_q * ACC_WIDTH'(INTERP_COST);
                    end
                    ModeDepth:  macs_d = pix_q * in_ext * ACC_WIDTH'(9);
                    ModePoint:  macs_d = pix_q * out_ext * in_ext;
                    default:    macs_d = full_macs;
                endcase
                state_d = StCalc3;
            end
            StCalc3: begin
                cost_d  = t_calc;
                count_d = t_calc;
                if (t_calc == '0) begin
                    complete = 1'b1;
                end else begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (count_q == ACC_WIDTH'(1)) begin
                    complete = 1'b1;
                end else begin
                    count_d = count_q - ACC_WIDTH'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Completion chains straight into the next queued job without an idle cycle.
        if (complete) begin
            done_d        = 1'b1;
            done_cycles_d = (state_q == StRun) ? cost_q : t_calc;
            done_mode_d   = cur_q.mode;
            job_count_d   = job_count_q + 16'd1;
            if (!fifo_empty) begin
                pop     = 1'b1;
                cur_d   = head_desc;
                state_d = StCalc1;
            end else begin
                state_d = StIdle;
            end
        end

        if (abort_i) begin
            state_d       = StIdle;
            pop           = 1'b0;
            done_d        = 1'b0;
            done_cycles_d = done_cycles_q;
            done_mode_d   = done_mode_q;
            job_count_d   = job_count_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cur_q         <= '0;
            pix_q         <= '0;
            macs_q        <= '0;
            interp_q      <= '0;
            cost_q        <= '0;
            count_q       <= '0;
            done_q        <= 1'b0;
            done_cycles_q <= '0;
            done_mode_q   <= '0;
            job_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            pix_q         <= pix_d;
            macs_q        <= macs_d;
            interp_q      <= interp_d;
            cost_q        <= cost_d;
            count_q       <= count_d;
            done_q        <= done_d;
            done_cycles_q <= done_cycles_d;
            done_mode_q   <= done_mode_d;
            job_count_q   <= job_count_d;
        end
    end

    assign busy_o        = (state_q != StIdle);
    assign done_o        = done_q;
    assign done_cycles_o = done_cycles_q;
    assign done_mode_o   = done_mode_q;
    assign job_count_o   = job_count_q;
    assign q_level_o     = q_cnt_q;

`ifdef CONV_CYCLE_STATS_EN
    logic [ACC_WIDTH-1:0] busy_total_q;

    // Survives abort on purpose; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_total_q <= '0;
        end else if (state_q != StIdle) begin
            busy_total_q <= busy_total_q + ACC_WIDTH'(1);
        end
    end

    assign busy_total_o = busy_total_q;
`endif

endmodule
